// File: rtl/sblk_row_inst_sched_if.sv
// rtl/sblk_row_inst_sched_if.sv - instruction input handshake between layer controller and row scheduler
interface sblk_row_inst_sched_if #(
    parameter int N_ROW    = 4,
    parameter int WID_INST = 14
);
    logic [WID_INST-1:0] inst_in_data;
    logic [N_ROW-1:0]    inst_in_mask;
    logic                inst_in_vld;
    logic                inst_in_rdy;

    modport master (
        output inst_in_data,
        output inst_in_mask,
        output inst_in_vld,
        input  inst_in_rdy
    );

    modport slave (
        input  inst_in_data,
        input  inst_in_mask,
        input  inst_in_vld,
        output inst_in_rdy
    );
endinterface

// File: rtl/sblk_row_inst_sched.sv
// rtl/sblk_row_inst_sched.sv - multicast instruction scheduler feeding N_ROW superblock rows
// Optional SBLK_SCHED_PERF_EN adds per-row saturating stall counters on perf_stall.
module sblk_row_inst_sched #(
    parameter int N_ROW       = 4,
    parameter int WID_INST    = 14,
    parameter int FIFO_DEPTH  = 4,
    parameter int WID_LVL     = $clog2(FIFO_DEPTH) + 1,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic                      clk_h,
    input  logic                      rst,
    sblk_row_inst_sched_if.slave      inst_in,
    output logic [WID_INST*N_ROW-1:0] inst_data,
    output logic [N_ROW-1:0]          inst_en,
    input  logic [N_ROW-1:0]          status_sblk,
    output logic [WID_LVL*N_ROW-1:0]  fifo_level,
    output logic [N_ROW-1:0]          err_timeout,
    output logic                      all_done
`ifdef SBLK_SCHED_PERF_EN
    ,
    output logic [32*N_ROW-1:0]       perf_stall
`endif
);
    localparam int AW      = WID_LVL - 1;
    localparam int WID_TMR = $clog2(ACK_TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WAIT_ACK = 2'd1,
        S_BUSY     = 2'd2
    } state_e;

    state_e              state_q [N_ROW];
    state_e              state_d [N_ROW];
    logic [WID_TMR-1:0]  timer_q [N_ROW];
    logic [WID_TMR-1:0]  timer_d [N_ROW];
    logic [WID_INST-1:0] data_q  [N_ROW];
    logic [WID_INST-1:0] data_d  [N_ROW];
    logic [WID_INST-1:0] mem_q   [N_ROW][FIFO_DEPTH];
    logic [WID_LVL-1:0]  wr_ptr_q[N_ROW];
    logic [WID_LVL-1:0]  rd_ptr_q[N_ROW];
    logic [WID_LVL-1:0]  level   [N_ROW];

    logic [N_ROW-1:0] en_q, en_d;
    logic [N_ROW-1:0] err_q, err_d;
    logic [N_ROW-1:0] full, empty, push, pop, idle;
    logic             in_rdy, hs;
    logic             all_done_q, all_done_d;

    always_comb begin
        full  = '0;
        empty = '0;
        for (int r = 0; r < N_ROW; r++) begin
            level[r] = wr_ptr_q[r] - rd_ptr_q[r];
            full[r]  = (level[r] == WID_LVL'(FIFO_DEPTH));
            empty[r] = (level[r] == '0);
        end
    end

    // Full check ignores a same-cycle pop, so a row that is draining may still refuse.
    assign in_rdy              = &(~inst_in.inst_in_mask | ~full);
    assign inst_in.inst_in_rdy = in_rdy;
    assign hs                  = inst_in.inst_in_vld & in_rdy;
    assign push                = {N_ROW{hs}} & inst_in.inst_in_mask;

    always_comb begin
        en_d  = '0;
        err_d = err_q;
        pop   = '0;
        idle  = '0;
        for (int r = 0; r < N_ROW; r++) begin
            state_d[r] = state_q[r];
            timer_d[r] = timer_q[r];
            data_d[r]  = data_q[r];
            case (state_q[r])
                S_IDLE: begin
                    idle[r] = 1'b1;
                    if (!empty[r] && !status_sblk[r]) begin
                        en_d[r]    = 1'b1;
                        data_d[r]  = mem_q[r][rd_ptr_q[r][AW-1:0]];
                        pop[r]     = 1'b1;
                        timer_d[r] = '0;
                        state_d[r] = S_WAIT_ACK;
                    end
                end
                S_WAIT_ACK: begin
                    if (status_sblk[r]) begin
                        state_d[r] = S_BUSY;
                    end else if (timer_q[r] == WID_TMR'(ACK_TIMEOUT - 1)) begin
                        err_d[r]   = 1'b1;
                        state_d[r] = S_IDLE;
                    end else begin
                        timer_d[r] = timer_q[r] + WID_TMR'(1);
                    end
                end
                S_BUSY: begin
                    if (!status_sblk[r]) state_d[r] = S_IDLE;
                end
                default: state_d[r] = S_IDLE;
            endcase
        end
    end

    // A handshake in the current cycle forces done low even if every row looks quiet.
    assign all_done_d = (&empty) & (&idle) & ~(|status_sblk) & ~hs;

    always_ff @(posedge clk_h) begin
        if (rst) begin
            en_q       <= '0;
            err_q      <= '0;
            all_done_q <= 1'b1;
            for (int r = 0; r < N_ROW; r++) begin
                state_q[r]  <= S_IDLE;
                timer_q[r]  <= '0;
                data_q[r]   <= '0;
                wr_ptr_q[r] <= '0;
                rd_ptr_q[r] <= '0;
            end
        end else begin
            en_q       <= en_d;
            err_q      <= err_d;
            all_done_q <= all_done_d;
            for (int r = 0; r < N_ROW; r++) begin
                state_q[r] <= state_d[r];
                timer_q[r] <= timer_d[r];
                data_q[r]  <= data_d[r];
                if (push[r]) wr_ptr_q[r] <= wr_ptr_q[r] + WID_LVL'(1);
                if (pop[r])  rd_ptr_q[r] <= rd_ptr_q[r] + WID_LVL'(1);
            end
        end
    end

    always_ff @(posedge clk_h) begin
        for (int r = 0; r < N_ROW; r++) begin
            if (push[r]) mem_q[r][wr_ptr_q[r][AW-1:0]] <= inst_in.inst_in_data;
        end
    end

    always_comb begin
        inst_data  = '0;
        fifo_level = '0;
        for (int r = 0; r < N_ROW; r++) begin
            inst_data[r*WID_INST +: WID_INST] = data_q[r];
            fifo_level[r*WID_LVL +: WID_LVL]  = level[r];
        end
    end

    assign inst_en     = en_q;
    assign err_timeout = err_q;
    assign all_done    = all_done_q;

`ifdef SBLK_SCHED_PERF_EN
    logic [31:0] perf_q [N_ROW];
    logic [1:0]  inc    [N_ROW];

    // Both stall sources can hit the same row in one cycle and each adds one.
    always_comb begin
        for (int r = 0; r < N_ROW; r++) begin
            inc[r] = 2'(idle[r] & ~empty[r] & status_sblk[r])
                   + 2'(inst_in.inst_in_vld & ~in_rdy & inst_in.inst_in_mask[r] & full[r]);
        end
    end

    always_ff @(posedge clk_h) begin
        for (int r = 0; r < N_ROW; r++) begin
            if (rst) begin
                perf_q[r] <= '0;
            end else if (perf_q[r] > (32'hFFFF_FFFF - 32'(inc[r]))) begin
                perf_q[r] <= 32'hFFFF_FFFF;
            end else begin
                perf_q[r] <= perf_q[r] + 32'(inc[r]);
            end
        end
    end

    always_comb begin
        perf_stall = '0;
        for (int r = 0; r < N_ROW; r++) perf_stall[r*32 +: 32] = perf_q[r];
    end
`endif
endmodule

// File: tb/tb_sblk_row_inst_sched.sv
// tb/tb_sblk_row_inst_sched.sv - directed self-checking bench for sblk_row_inst_sched
module tb_sblk_row_inst_sched;
    localparam int N_ROW = 4;
    localparam int WID_INST = 14;
    localparam int WID_LVL = 3;

    logic clk_h = 1'b0;
    logic rst = 1'b1;
    logic [WID_INST*N_ROW-1:0] inst_data;
    logic [N_ROW-1:0] inst_en;
    logic [N_ROW-1:0] status_sblk = '0;
    logic [WID_LVL*N_ROW-1:0] fifo_level;
    logic [N_ROW-1:0] err_timeout;
    logic all_done;
`ifdef SBLK_SCHED_PERF_EN
    logic [32*N_ROW-1:0] perf_stall;
`endif

    int total = 0;
    int bad = 0;

    sblk_row_inst_sched_if #(.N_ROW(N_ROW), .WID_INST(WID_INST)) bus ();

    sblk_row_inst_sched #(
        .N_ROW(N_ROW), .WID_INST(WID_INST), .FIFO_DEPTH(4), .ACK_TIMEOUT(16)
    ) dut (
        .clk_h(clk_h),
        .rst(rst),
        .inst_in(bus.slave),
        .inst_data(inst_data),
        .inst_en(inst_en),
        .status_sblk(status_sblk),
        .fifo_level(fifo_level),
        .err_timeout(err_timeout),
        .all_done(all_done)
`ifdef SBLK_SCHED_PERF_EN
        ,
        .perf_stall(perf_stall)
`endif
    );

    always #5 clk_h = ~clk_h;

    task automatic tick();
        @(posedge clk_h);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        bus.inst_in_data = '0;
        bus.inst_in_mask = '0;
        bus.inst_in_vld  = 1'b0;

        // 1. reset state and single-row issue latency
        rst = 1'b1;
        tick();
        tick();
        chk("rst_rdy", bus.inst_in_rdy, 1);
        chk("rst_done", all_done, 1);
        chk("rst_en", inst_en, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_err", err_timeout, 0);
        chk("rst_data", inst_data, 0);
        rst = 1'b0;
        tick();
        bus.inst_in_data = 14'h1234;
        bus.inst_in_mask = 4'b0001;
        bus.inst_in_vld  = 1'b1;
        tick();
        bus.inst_in_vld = 1'b0;
        chk("t1_n1_en", inst_en, 0);
        chk("t1_n1_level", fifo_level, 12'h001);
        chk("t1_n1_done", all_done, 0);
        tick();
        chk("t1_n2_en", inst_en, 4'b0001);
        chk("t1_n2_data", inst_data[13:0], 14'h1234);
        chk("t1_n2_level", fifo_level, 0);
        tick();
        chk("t1_en_width", inst_en, 0);
        status_sblk = 4'b0001;
        for (int i = 0; i < 5; i++) tick();
        status_sblk = 4'b0000;
        chk("t1_busy_done", all_done, 0);
        tick();
        chk("t1_fall_done", all_done, 0);
        tick();
        chk("t1_done_back", all_done, 1);
        chk("t1_data_hold", inst_data[13:0], 14'h1234);

        // 2. broadcast into full FIFOs with all rows busy
        status_sblk = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            bus.inst_in_data = 14'(16'h100 + i);
            bus.inst_in_mask = 4'b1111;
            bus.inst_in_vld  = 1'b1;
            #1;
            chk($sformatf("t2_rdy%0d", i), bus.inst_in_rdy, (i < 4) ? 1 : 0);
            tick();
        end
        bus.inst_in_vld = 1'b0;
        chk("t2_level_full", fifo_level, 12'h924);
        chk("t2_no_en", inst_en, 0);
        tick();
        tick();
        chk("t2_hold_en", inst_en, 0);

        // 3. staggered release; each row issues alone and in FIFO order
        status_sblk = 4'b1110;
        tick();
        chk("t3_en_r0", inst_en, 4'b0001);
        chk("t3_data_r0", inst_data[13:0], 14'h100);
        chk("t3_level_r0", fifo_level, 12'h923);
        status_sblk = 4'b1101;
        tick();
        chk("t3_en_r1", inst_en, 4'b0010);
        chk("t3_data_r1", inst_data[27:14], 14'h100);
        status_sblk = 4'b1011;
        tick();
        chk("t3_en_r2", inst_en, 4'b0100);
        chk("t3_data_r2", inst_data[41:28], 14'h100);
        status_sblk = 4'b0111;
        tick();
        chk("t3_en_r3", inst_en, 4'b1000);
        chk("t3_data_r3", inst_data[55:42], 14'h100);
        chk("t3_level_all3", fifo_level, 12'h6DB);
        status_sblk = 4'b1110;
        tick();
        chk("t3_r0_release", inst_en, 0);
        tick();
        chk("t3_en_r0_2nd", inst_en, 4'b0001);
        chk("t3_data_r0_2nd", inst_data[13:0], 14'h101);
        chk("t3_level_r0_2nd", fifo_level[2:0], 3'd2);

        // 4. row 2 never acknowledges
        do_reset();
        status_sblk = 4'b0000;
        bus.inst_in_mask = 4'b0100;
        bus.inst_in_vld  = 1'b1;
        bus.inst_in_data = 14'h2A0;
        tick();
        bus.inst_in_data = 14'h2A1;
        tick();
        bus.inst_in_vld = 1'b0;
        chk("t4_issue", inst_en, 4'b0100);
        chk("t4_issue_data", inst_data[41:28], 14'h2A0);
        for (int i = 0; i < 15; i++) tick();
        chk("t4_err_early", err_timeout, 0);
        tick();
        chk("t4_err_set", err_timeout, 4'b0100);
        tick();
        chk("t4_next_issue", inst_en, 4'b0100);
        chk("t4_next_data", inst_data[41:28], 14'h2A1);
        for (int i = 0; i < 5; i++) tick();
        chk("t4_err_sticky", err_timeout, 4'b0100);

        // 5. reset while busy with queued work, then mask=0 handshake
        do_reset();
        status_sblk = 4'b0000;
        bus.inst_in_mask = 4'b1111;
        bus.inst_in_vld  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.inst_in_data = 14'(16'h50 + i);
            tick();
        end
        bus.inst_in_vld = 1'b0;
        status_sblk = 4'b1111;
        tick();
        chk("t5_level_pre", fifo_level, 12'h492);
        chk("t5_data_pre", inst_data[55:42], 14'h50);
        rst = 1'b1;
        tick();
        chk("t5_level_rst", fifo_level, 0);
        chk("t5_en_rst", inst_en, 0);
        chk("t5_data_rst", inst_data, 0);
        chk("t5_err_rst", err_timeout, 0);
        rst = 1'b0;
        status_sblk = 4'b0000;
        tick();
        bus.inst_in_mask = 4'b0000;
        bus.inst_in_data = 14'h3FFF;
        bus.inst_in_vld  = 1'b1;
        #1;
        chk("t5_mask0_rdy", bus.inst_in_rdy, 1);
        tick();
        bus.inst_in_vld = 1'b0;
        chk("t5_mask0_level", fifo_level, 0);
        chk("t5_mask0_done_drop", all_done, 0);
        tick();
        chk("t5_mask0_en", inst_en, 0);
        chk("t5_mask0_done_back", all_done, 1);

`ifdef SBLK_SCHED_PERF_EN
        // 6. stall counter on row 1
        do_reset();
        status_sblk = 4'b0010;
        bus.inst_in_mask = 4'b0010;
        bus.inst_in_data = 14'h0777;
        bus.inst_in_vld  = 1'b1;
        tick();
        bus.inst_in_vld = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        chk("t6_perf_r1", perf_stall[63:32], 32'd10);
        chk("t6_perf_r0", perf_stall[31:0], 0);
        chk("t6_perf_r23", perf_stall[127:64], 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
